systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Collects results leaving the bottom edge of the systolic PE array and undoes the one-cycle-per-column skew, so that every column of a row is aligned.
- Buffers each aligned row in a small FIFO and hands rows to the downstream writeback through a valid/ready handshake.
- Tags the last row of each tile.
- The array has no stall path, so this block drops rows on overflow, reports the loss, and raises almost-full early so the scheduler can throttle.

Parameters:
- DATA_WIDTH, 32, width of one column element; matches the PE data width.
- NUM_COLS, 4, number of array columns drained (>=1).
- FIFO_DEPTH, 4, aligned-row buffer entries (power of two, >=2).
- ROWS_PER_TILE, 4, rows per output tile; used for row_last (>=1).
- AFULL_SLACK, NUM_COLS, almost_full asserts when free entries are at or below ceil(AFULL_SLACK/1). It must cover rows already in flight in the skew.

Ports:
- clk  in  1  clock
- reset_accumulator  in  1  synchronous, active-high reset, shared with the array
- col_data  in  NUM_COLS*DATA_WIDTH  bottom-edge PE outputs; column j occupies bits [j*DATA_WIDTH +: DATA_WIDTH]
- row_start  in  1  column 0 of a new row is valid this cycle; column j of that row is valid j cycles later
- row_data  out  NUM_COLS*DATA_WIDTH  aligned row at the FIFO head
- row_valid  out  1  FIFO non-empty
- row_ready  in  1  downstream accepts
- row_last  out  1  head row is row index ROWS_PER_TILE-1 of its tile
- almost_full  out  1  throttle hint to the scheduler
- overflow  out  1  sticky; a row was dropped

Behaviour:
- Reset: all outputs 0. Delay lines, in-flight markers, FIFO pointers, row counter and overflow are cleared.
- Reset mid-operation: all in-flight and buffered rows are discarded. The first cycle after reset deasserts is a normal cycle.
- Deskew: column j passes through NUM_COLS-1-j register stages. Column NUM_COLS-1 has no delay. row_start passes through an NUM_COLS-1 stage marker pipe.
- Alignment: when the marker pipe output is high (cycle t+NUM_COLS-1 for row_start at t), the aligned row is written into the FIFO on that edge.
- Latency: row_valid rises in cycle t+NUM_COLS when the FIFO was empty. There is no empty-bypass.
- Back-to-back rows: row_start may be high every cycle. Throughput is one row per cycle.
- Handshake: a transfer happens when row_valid and row_ready are both high at a rising edge. row_data and row_last stay stable while row_valid is high and row_ready is low.
- Full FIFO with simultaneous pop: the write is accepted and the count is unchanged.
- Full FIFO without pop: the aligned row is dropped, overflow sets and holds until reset, and the row counter still advances so tile framing stays correct.
- Empty FIFO: row_ready is ignored and pointers do not move.
- Row counter: 0..ROWS_PER_TILE-1 and wraps to 0. The count value is stored in the FIFO alongside the data. row_last = (stored count == ROWS_PER_TILE-1).
- Pointers: log2(FIFO_DEPTH)+1 bits with a wrap bit. full and empty are derived from pointer compare.
- almost_full: (FIFO_DEPTH - count) <= AFULL_SLACK, registered and updated every cycle.

Optional Feature:
- DRAIN_DROP_CNT_EN defined: adds output port drop_count [15:0].
  - Increments by 1 per dropped row and saturates at 16'hFFFF.
  - Clears on reset.
- Not defined: the port and counter are absent. Only the sticky overflow flag reports drops.

Decomposition:
- Shared package/header sigma_pkg:
  - default DATA_WIDTH
  - clog2 function
  - FIFO_PTR_W derivation
  - row-tag width constant
- Sub-module drain_fifo: synchronous FIFO with width NUM_COLS*DATA_WIDTH+tag bits, depth FIFO_DEPTH, same clk and reset_accumulator. It provides push, pop, full, empty and count.
- Deskew and tagging stay in systolic_drain.

Test Plan:
- Single row: NUM_COLS=4; row_start at t=10; col j = 100+j driven at cycle 10+j; row_ready=1 -> row_valid high only at t=14, row_data={103,102,101,100}, row_last=0.
- Four back-to-back rows with values 10r+j and ready=1 -> four consecutive valid cycles in order; row_last=1 only on the 4th; the 5th row has row_last=0 (wrap).
- row_ready=0 and 4 rows pushed -> FIFO full; row data held stable; almost_full=1 once free entries <=4; a 5th row is dropped, overflow=1, drop_count=1 with DRAIN_DROP_CNT_EN.
- Full FIFO with row_ready=1 on the same cycle a new row aligns -> row accepted, no overflow, order preserved.
- Reset asserted for 1 cycle while 2 rows are in the skew and 2 are buffered -> row_valid=0, overflow=0 next cycle; a subsequent row emerges with row_last tag index 0 and correct latency.
- Random row_ready over 200 rows without overflow -> scoreboard matches all rows and all row_last tags.

Source files
------------

// File: rtl/sigma_pkg.sv
// Shared constants and helpers for the systolic drain path.
// Pointer widths carry one extra wrap bit; row tags hold the row index within a tile.
package sigma_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Row index tag stored next to each buffered row; limits ROWS_PER_TILE to 256.
  localparam int ROW_TAG_W = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return r;
  endfunction

  function automatic int fifo_ptr_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO for aligned rows; write-to-read latency one cycle, no bypass.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module drain_fifo
  import sigma_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_accumulator,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_dat,
  output logic                         full,
  output logic                         empty,
  output logic [fifo_ptr_w(DEPTH)-1:0] count
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign pop_ok  = pop && !empty;
  // When full, the slot being written is the one being popped this edge.
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_accumulator) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/systolic_drain.sv
// Deskews bottom-edge PE outputs into aligned rows, buffers them, tags tile-last rows; row_start to row_valid is NUM_COLS cycles.
// No stall upstream: full FIFO without pop drops the row (sticky overflow); DRAIN_DROP_CNT_EN adds a saturating drop_count.
module systolic_drain
  import sigma_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int NUM_COLS      = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int ROWS_PER_TILE = 4,
  parameter int AFULL_SLACK   = NUM_COLS
) (
  input  logic                           clk,
  input  logic                           reset_accumulator,
  input  logic [NUM_COLS*DATA_WIDTH-1:0] col_data,
  input  logic                           row_start,
  output logic [NUM_COLS*DATA_WIDTH-1:0] row_data,
  output logic                           row_valid,
  input  logic                           row_ready,
  output logic                           row_last,
  output logic                           almost_full,
  output logic                           overflow
`ifdef DRAIN_DROP_CNT_EN
  ,
  output logic [15:0]                    drop_count
`endif
);

  localparam int ROW_W = NUM_COLS * DATA_WIDTH;
  localparam int PW    = fifo_ptr_w(FIFO_DEPTH);
  localparam int ENT_W = ROW_W + ROW_TAG_W;
  localparam int unsigned SLACK_U = AFULL_SLACK;
  localparam logic [ROW_TAG_W-1:0] LAST_IDX = ROW_TAG_W'(ROWS_PER_TILE - 1);

  logic [ROW_W-1:0]     aligned_row;
  logic                 mark_out;
  logic [ROW_TAG_W-1:0] row_cnt_q, row_cnt_d;
  logic                 overflow_q, overflow_d;
  logic                 almost_full_q, almost_full_d;
  logic                 fifo_full, fifo_empty;
  logic [PW-1:0]        fifo_count;
  logic [PW-1:0]        free_cnt;
  logic [ENT_W-1:0]     head_dat;
  logic                 drop;

  // Column j waits NUM_COLS-1-j cycles so it lines up with the last column.
  for (genvar j = 0; j < NUM_COLS; j++) begin : g_col
    localparam int STG = NUM_COLS - 1 - j;
    if (STG == 0) begin : g_pass
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = col_data[j*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_dly
      logic [DATA_WIDTH-1:0] dly_q [STG];
      always_ff @(posedge clk) begin
        if (reset_accumulator) begin
          for (int k = 0; k < STG; k++) dly_q[k] <= '0;
        end else begin
          dly_q[0] <= col_data[j*DATA_WIDTH +: DATA_WIDTH];
          for (int k = 1; k < STG; k++) dly_q[k] <= dly_q[k-1];
        end
      end
      assign aligned_row[j*DATA_WIDTH +: DATA_WIDTH] = dly_q[STG-1];
    end
  end

  if (NUM_COLS == 1) begin : g_mark_none
    assign mark_out = row_start;
  end else begin : g_mark
    logic [NUM_COLS-2:0] mark_q, mark_d;
    always_comb begin
      mark_d    = '0;
      mark_d[0] = row_start;
      for (int k = 1; k < NUM_COLS - 1; k++) mark_d[k] = mark_q[k-1];
    end
    always_ff @(posedge clk) begin
      if (reset_accumulator) mark_q <= '0;
      else                   mark_q <= mark_d;
    end
    assign mark_out = mark_q[NUM_COLS-2];
  end

  drain_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk               (clk),
    .reset_accumulator (reset_accumulator),
    .push              (mark_out),
    .push_dat          ({row_cnt_q, aligned_row}),
    .pop               (row_ready),
    .pop_dat           (head_dat),
    .full              (fifo_full),
    .empty             (fifo_empty),
    .count             (fifo_count)
  );

  assign drop     = mark_out && fifo_full && !row_ready;
  assign free_cnt = PW'(FIFO_DEPTH) - fifo_count;

  always_comb begin
    row_cnt_d     = row_cnt_q;
    overflow_d    = overflow_q || drop;
    almost_full_d = (32'(free_cnt) <= SLACK_U);
    // Dropped rows still count so tile framing survives an overflow.
    if (mark_out) row_cnt_d = (row_cnt_q == LAST_IDX) ? '0 : row_cnt_q + ROW_TAG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_accumulator) begin
      row_cnt_q     <= '0;
      overflow_q    <= 1'b0;
      almost_full_q <= 1'b0;
    end else begin
      row_cnt_q     <= row_cnt_d;
      overflow_q    <= overflow_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign row_valid   = !fifo_empty;
  assign row_data    = fifo_empty ? '0 : head_dat[ROW_W-1:0];
  assign row_last    = !fifo_empty && (head_dat[ENT_W-1:ROW_W] == LAST_IDX);
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;

`ifdef DRAIN_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset_accumulator) drop_cnt_q <= '0;
    else                   drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: queue-level reference model checked every cycle plus directed literal checks.
module tb_systolic_drain;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int RPT   = 4;
  localparam int SLACK = 4;
  localparam int RW    = N * DW;

  logic          clk = 1'b0;
  logic          reset_accumulator;
  logic [RW-1:0] col_data;
  logic          row_start;
  logic          row_ready;
  logic [RW-1:0] row_data;
  logic          row_valid;
  logic          row_last;
  logic          almost_full;
  logic          overflow;
`ifdef DRAIN_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

  always #5 clk = ~clk;

  systolic_drain #(
    .DATA_WIDTH    (DW),
    .NUM_COLS      (N),
    .FIFO_DEPTH    (DEPTH),
    .ROWS_PER_TILE (RPT),
    .AFULL_SLACK   (SLACK)
  ) dut (
    .clk               (clk),
    .reset_accumulator (reset_accumulator),
    .col_data          (col_data),
    .row_start         (row_start),
    .row_data          (row_data),
    .row_valid         (row_valid),
    .row_ready         (row_ready),
    .row_last          (row_last),
    .almost_full       (almost_full),
    .overflow          (overflow)
`ifdef DRAIN_DROP_CNT_EN
    ,
    .drop_count        (drop_count)
`endif
  );

  typedef struct packed {
    logic [RW-1:0] d;
    logic          last;
  } ent_t;

  // Reference model: rows started j cycles ago, buffered rows, tile position, flags.
  ent_t          mq[$];
  bit            sh_st[N];
  logic [RW-1:0] sh_d[N];
  int            rowcnt, drops_m, pops_m;
  bit            ovf_m, af_m;
  bit            chk_en;
  int            errors, checks;

  logic          s_valid, s_last, s_af, s_ovf;
  logic [RW-1:0] s_data;
  logic [15:0]   s_drop;

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int base);
    logic [RW-1:0] r;
    for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(base + j);
    return r;
  endfunction

  task automatic cycle(input bit st, input logic [RW-1:0] rv, input bit rdy, input bit rst);
    bit pop, push, was_full, af_next;
    for (int k = N - 1; k > 0; k--) begin
      sh_st[k] = sh_st[k-1];
      sh_d[k]  = sh_d[k-1];
    end
    sh_st[0] = st;
    sh_d[0]  = rv;
    reset_accumulator = rst;
    row_start = st;
    row_ready = rdy;
    for (int j = 0; j < N; j++)
      col_data[j*DW +: DW] = sh_st[j] ? sh_d[j][j*DW +: DW] : DW'($urandom);

    @(negedge clk);
    s_valid = row_valid;
    s_data  = row_data;
    s_last  = row_last;
    s_af    = almost_full;
    s_ovf   = overflow;
`ifdef DRAIN_DROP_CNT_EN
    s_drop  = drop_count;
`else
    s_drop  = '0;
`endif
    if (chk_en) begin
      chk("row_valid", RW'(row_valid), RW'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("row_data", row_data, mq[0].d);
        chk("row_last", RW'(row_last), RW'(mq[0].last));
      end
      chk("overflow", RW'(overflow), RW'(ovf_m));
      chk("almost_full", RW'(almost_full), RW'(af_m));
`ifdef DRAIN_DROP_CNT_EN
      chk("drop_count", RW'(drop_count), RW'(16'(drops_m)));
`endif
    end

    if (rst) begin
      mq.delete();
      rowcnt  = 0;
      ovf_m   = 1'b0;
      af_m    = 1'b0;
      drops_m = 0;
      for (int k = 0; k < N; k++) sh_st[k] = 1'b0;
    end else begin
      af_next  = (DEPTH - mq.size()) <= SLACK;
      pop      = (mq.size() != 0) && rdy;
      push     = sh_st[N-1];
      was_full = (mq.size() == DEPTH);
      if (pop) begin
        void'(mq.pop_front());
        pops_m++;
      end
      if (push) begin
        if (!was_full || pop) mq.push_back('{d: sh_d[N-1], last: (rowcnt == RPT - 1)});
        else begin
          ovf_m = 1'b1;
          if (drops_m < 65535) drops_m++;
        end
        rowcnt = (rowcnt + 1) % RPT;
      end
      af_m = af_next;
    end

    @(posedge clk);
    #1;
  endtask

  logic          v[8], lk[8];
  logic [RW-1:0] dk[8];
  logic          lastq[$];
  logic [RW-1:0] dq[$];
  logic [4:0]    lv;
  int            started, inflight;
  bit            st;

  initial begin
    errors = 0; checks = 0; chk_en = 1'b0;
    rowcnt = 0; drops_m = 0; pops_m = 0; ovf_m = 1'b0; af_m = 1'b0;
    for (int k = 0; k < N; k++) begin sh_st[k] = 1'b0; sh_d[k] = '0; end
    reset_accumulator = 1'b1; row_start = 1'b0; row_ready = 1'b0; col_data = '0;

    cycle(0, '0, 0, 1);
    chk_en = 1'b1;
    cycle(0, '0, 0, 1);
    chk("reset_valid", RW'(s_valid), '0);
    chk("reset_ovf", RW'(s_ovf), '0);
    chk("reset_af", RW'(s_af), '0);
    chk("reset_data", s_data, '0);

    // Single row: valid exactly 4 cycles after row_start.
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);
    cycle(1, mkrow(100), 1, 0);
    for (int k = 1; k < 7; k++) begin
      cycle(0, '0, 1, 0);
      v[k] = s_valid; dk[k] = s_data; lk[k] = s_last;
    end
    chk("t1_valid_c3", RW'(v[3]), '0);
    chk("t1_valid_c4", RW'(v[4]), RW'(1));
    chk("t1_data", dk[4], {32'd103, 32'd102, 32'd101, 32'd100});
    chk("t1_last", RW'(lk[4]), '0);
    chk("t1_valid_c5", RW'(v[5]), '0);

    // Five back-to-back rows: only the fourth is tile-last.
    cycle(0, '0, 0, 1);
    lastq.delete(); dq.delete();
    for (int i = 0; i < 14; i++) begin
      cycle(i < 5, mkrow(10 * i), 1, 0);
      if (s_valid) begin lastq.push_back(s_last); dq.push_back(s_data); end
    end
    chk("t3_count", RW'(lastq.size()), RW'(5));
    if (lastq.size() == 5) begin
      for (int i = 0; i < 5; i++) lv[i] = lastq[i];
      chk("t3_lasts", RW'(lv), RW'(5'b01000));
      chk("t3_first", dq[0], {32'd3, 32'd2, 32'd1, 32'd0});
      chk("t3_fifth", dq[4], {32'd43, 32'd42, 32'd41, 32'd40});
    end

    // Stalled consumer: fill, hold head stable, drop the fifth row.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 11; i++) cycle(i < 5, mkrow(10 * i), 0, 0);
    chk("t4_ovf", RW'(s_ovf), RW'(1));
    chk("t4_valid", RW'(s_valid), RW'(1));
    chk("t4_head", s_data, {32'd3, 32'd2, 32'd1, 32'd0});
    chk("t4_af", RW'(s_af), RW'(1));
`ifdef DRAIN_DROP_CNT_EN
    chk("t4_drops", RW'(s_drop), RW'(1));
`endif
    for (int i = 0; i < 8; i++) cycle(0, '0, 1, 0);
    chk("t4_drained", RW'(s_valid), '0);
    chk("t4_ovf_sticky", RW'(s_ovf), RW'(1));

    // Full FIFO with a pop on the very edge a new row aligns.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 10; i++) cycle(i < 5, mkrow(10 * i), i == 7, 0);
    chk("t5_ovf", RW'(s_ovf), '0);
    chk("t5_head", s_data, {32'd13, 32'd12, 32'd11, 32'd10});
    dq.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(0, '0, 1, 0);
      if (s_valid) dq.push_back(s_data);
    end
    chk("t5_count", RW'(dq.size()), RW'(4));
    if (dq.size() == 4) chk("t5_tail", dq[3], {32'd43, 32'd42, 32'd41, 32'd40});

    // Reset with two rows buffered and two in the skew.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 7; i++) cycle(i == 0 || i == 1 || i == 4 || i == 5, mkrow(50 + 10 * i), 0, i == 6);
    cycle(1, mkrow(200), 1, 0);
    chk("t6_valid_after_rst", RW'(s_valid), '0);
    chk("t6_ovf_after_rst", RW'(s_ovf), '0);
    for (int k = 1; k < 7; k++) begin
      cycle(0, '0, 1, 0);
      v[k] = s_valid; dk[k] = s_data; lk[k] = s_last;
    end
    chk("t6_valid_c3", RW'(v[3]), '0);
    chk("t6_valid_c4", RW'(v[4]), RW'(1));
    chk("t6_data", dk[4], {32'd203, 32'd202, 32'd201, 32'd200});
    chk("t6_last", RW'(lk[4]), '0);
    chk("t6_valid_c5", RW'(v[5]), '0);

    // Random ready over 200 rows, starts throttled so nothing is dropped.
    cycle(0, '0, 0, 1);
    pops_m = 0; started = 0;
    for (int c = 0; c < 5000 && started < 200; c++) begin
      inflight = 0;
      for (int k = 0; k < N - 1; k++) inflight += int'(sh_st[k]);
      st = ($urandom_range(0, 99) < 60) && (mq.size() + inflight + 1 <= DEPTH);
      cycle(st, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 99) < 65, 0);
      if (st) started++;
    end
    for (int c = 0; c < 200 && (mq.size() != 0 || sh_st[0] || sh_st[1] || sh_st[2] || sh_st[3]); c++)
      cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 0);
    chk("t7_started", RW'(started), RW'(200));
    chk("t7_pops", RW'(pops_m), RW'(200));
    chk("t7_ovf", RW'(s_ovf), '0);
    chk("t7_empty", RW'(s_valid), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
